// File: rtl/regdump_pkg.sv
// Shared constants for the register-file dump engine: FSM encodings and default geometry.
package regdump_pkg;

  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT    = 5;
  localparam int unsigned DW_DEFAULT    = 32;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StSend  = 2'd2;
  localparam logic [1:0] StCsum  = 2'd3;

endpackage

// File: rtl/regfile_dump.sv
// Streams every register-file entry (index 0..NREGS-1) over a valid/ready channel.
// Optional trailing XOR checksum word when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic [AW-1:0] radd,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          out_is_csum
);

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] radd_q, radd_d;
  logic [AW-1:0] index_q, index_d;
  logic [DW-1:0] data_q, data_d;
  logic          is_last;

  assign is_last = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    radd_d  = radd_q;
    index_d = index_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          idx_d   = '0;
          radd_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          data_d  = rdata;
          index_d = idx_q;
          state_d = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (is_last) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StIdle;
`endif
          end else begin
            // radd only moves on the way into FETCH so the read port sees a stable address
            idx_d   = idx_q + AW'(1);
            radd_d  = idx_q + AW'(1);
            state_d = StFetch;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      StCsum: begin
        if (abort || out_ready) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      radd_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      radd_q  <= radd_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign radd = radd_q;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] acc_q, acc_d;
  logic          send_hs;

  // An aborted word is not delivered, so it never reaches the checksum.
  assign send_hs = (state_q == StSend) && out_ready && !abort;

  always_comb begin
    acc_d = acc_q;
    if (state_q == StIdle && start && !abort) begin
      acc_d = '0;
    end else if (send_hs) begin
      acc_d = acc_q ^ data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign out_valid   = (state_q == StSend) || (state_q == StCsum);
  assign out_data    = (state_q == StCsum) ? acc_q : data_q;
  assign out_index   = (state_q == StCsum) ? '0 : index_q;
  assign out_last    = (state_q == StCsum);
  assign out_is_csum = (state_q == StCsum);
`else
  assign out_valid   = (state_q == StSend);
  assign out_data    = data_q;
  assign out_index   = index_q;
  assign out_last    = (state_q == StSend) && is_last;
  assign out_is_csum = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump; build with REGDUMP_CHECKSUM_EN to cover the checksum word.
module tb_regfile_dump;
  import regdump_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
    logic        csum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [4:0]  radd;
  logic [31:0] rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        out_is_csum;

  logic [31:0] rf [32];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;

  regfile_dump dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .radd        (radd),
    .rdata       (rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_is_csum (out_is_csum)
  );

  // Register-file model: index 0 reads as zero.
  assign rdata = (radd == 5'd0) ? 32'd0 : rf[radd];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented word must match the scoreboard head; pop on a real handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h/%0h required=none", out_index, out_data);
      end else begin
        chk($sformatf("word_idx%0d", sb[0].idx),
            {25'd0, out_data, out_index, out_last, out_is_csum}, {25'd0, sb[0]});
        if (out_ready && !abort) void'(sb.pop_front());
      end
    end
  end

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
  endtask

  task automatic push_dump(input bit wr);
    exp_t e;
`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] acc;
    acc = 32'd0;
`endif
    for (int i = 0; i < 32; i++) begin
      e.data = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
      if (wr && i == 25) e.data = 32'hDEAD_BEEF;
      e.idx  = 5'(i);
      e.csum = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      e.last = 1'b0;
      acc    = acc ^ e.data;
`else
      e.last = (i == 31);
`endif
      sb.push_back(e);
    end
`ifdef REGDUMP_CHECKSUM_EN
    e.data = acc;
    e.idx  = 5'd0;
    e.last = 1'b1;
    e.csum = 1'b1;
    sb.push_back(e);
`endif
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, busy, radd, out_valid, out_data, out_index, out_last, out_is_csum};
  endfunction

  // Runs one dump; -1 disables each event. Events key on the index currently in SEND.
  task automatic run_dump(input int stall_idx, input int abort_idx, input int wr_idx,
                          input int start2_idx, input int rst_idx);
    int it = 1;
    int stall = 0;
    int hs_it = -1;
    bit done = 1'b0;
    bit cut = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("fetch_no_valid", out_valid, 0);
    while (!done && it < 400) begin
      @(posedge clk); #1;
      it++;
      start = 1'b0;
      abort = 1'b0;
      out_ready = 1'b1;
      if (it == 2) chk("first_valid_latency", out_valid, 1);
      if (!busy) begin
        done = 1'b1;
      end else if (out_valid && !out_is_csum) begin
        if (hs_it >= 0 && int'(out_index) == stall_idx + 1) begin
          chk("post_stall_next_word", it, hs_it + 2);
          hs_it = -1;
        end
        if (int'(out_index) == stall_idx) begin
          if (stall < 7) begin
            out_ready = 1'b0;
            stall++;
          end else if (stall == 7) begin
            hs_it = it;
            stall++;
          end
        end
        if (int'(out_index) == wr_idx) rf[25] = 32'hDEAD_BEEF;
        if (int'(out_index) == start2_idx) start = 1'b1;
        if (int'(out_index) == abort_idx) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_valid", out_valid, 0);
          sb.delete();
          done = 1'b1;
          cut = 1'b1;
        end else if (int'(out_index) == rst_idx) begin
          rst = 1'b1;
          #1;
          chk("rst_async_outputs", all_outs(), 64'd0);
          sb.delete();
          @(posedge clk); #1;
          rst = 1'b0;
          @(posedge clk); #1;
          chk("post_rst_outputs", all_outs(), 64'd0);
          done = 1'b1;
          cut = 1'b1;
        end
      end
    end
    chk("dump_terminates", done, 1);
    if (!cut) begin
`ifdef REGDUMP_CHECKSUM_EN
      if (stall_idx < 0) chk("dump_cycles", it - 1, 65);
`else
      if (stall_idx < 0) chk("dump_cycles", it - 1, 64);
`endif
      chk("all_words_seen", sb.size(), 0);
    end
  endtask

  initial begin
    preload();
    #12;
    chk("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("idle_outputs", all_outs(), 64'd0);

    // Plain dump with out_ready held high.
    push_dump(1'b0);
    run_dump(-1, -1, -1, -1, -1);

    // Back-pressure on index 3.
    push_dump(1'b0);
    run_dump(3, -1, -1, -1, -1);

    // Abort in SEND of index 10 with a simultaneous ready, then a clean restart.
    push_dump(1'b0);
    run_dump(-1, 10, -1, -1, -1);
    push_dump(1'b0);
    run_dump(-1, -1, -1, -1, -1);

    // Live write to reg 25 while index 12 is being presented.
    push_dump(1'b1);
    run_dump(-1, -1, 12, -1, -1);
    preload();

    // Start while busy is ignored; reset mid-dump at index 20.
    push_dump(1'b0);
    run_dump(-1, -1, -1, 5, 20);

    // start together with abort in IDLE must not launch a dump.
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_quiet", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
